// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- write-side handshake bundle for uart_tx_fifo.
//
// Signals:
//   wr_valid : producer presents a byte this cycle
//   wr_data  : byte to transmit
//   wr_ready : FIFO can accept a byte (not full)
//
// Modports:
//   master : the producer (drives valid/data, observes ready)
//   slave  : the FIFO (observes valid/data, drives ready)

interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO feeding an 8N1 UART transmitter (LSB first,
// idle-high line). Frames are sent back-to-back with no idle gap while the
// FIFO holds data.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (2..65535)
//   DEPTH_LOG2   : FIFO depth = 2**DEPTH_LOG2 bytes
//
// Ports:
//   clock    : single clock for all logic
//   reset    : synchronous active-high reset
//   wr       : write handshake (uart_tx_fifo_if.slave)
//   tx       : registered serial output
//   busy     : high while a frame is in progress or the FIFO is non-empty
//   level    : current FIFO occupancy, 0..depth
//
// Configuration:
//   UART_TX_PARITY_EN : when defined, an even-parity bit is inserted after the
//                       data bits (11-bit frame); otherwise 8N1 (10-bit frame).

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_tx_fifo_if.slave         wr,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]            fifo_mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full_q, full_d;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_q, tx_d;

  logic push;
  logic pop;
  logic [7:0] head;

  // wr_ready depends only on the registered full flag, so a pop in a full
  // cycle cannot re-open the FIFO until the following cycle.
  assign wr.wr_ready = ~full_q;
  assign push        = wr.wr_valid & ~full_q & ~reset;
  assign head        = fifo_mem_q[rd_ptr_q];

  assign tx    = tx_q;
  assign level = level_q;
  assign busy  = (state_q != IDLE) || (level_q != '0);

  // Transmit state machine. tx_d is computed together with the next state so
  // the line changes on the same edge the state does; the baud counter is
  // reloaded on every state or bit change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (level_q != '0) begin
          pop       = 1'b1;
          tx_byte_d = head;
          state_d   = START;
          cnt_d     = RELOAD;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          cnt_d     = RELOAD;
          tx_d      = tx_byte_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = RELOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^tx_byte_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = tx_byte_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == 16'd0) begin
          state_d = STOP;
          cnt_d   = RELOAD;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next frame when data is waiting.
          if (level_q != '0) begin
            pop       = 1'b1;
            tx_byte_d = head;
            state_d   = START;
            cnt_d     = RELOAD;
            tx_d      = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally at their width.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == DEPTH_LVL);
  end

  // Storage array has no reset; only the pointers and level define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  // State registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      tx_byte_q <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- self-checking bench for uart_tx_fifo. A queue-based
// reference model tracks accepted bytes and the frame timeline in whole
// cycles; the DUT's tx/level/busy/wr_ready are compared every cycle.

module tb_uart_tx_fifo;
  localparam int CPB        = 4;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_LEN  = FRAME_BITS * CPB;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                tx;
  logic                busy;
  logic [DEPTH_LOG2:0] level;

  uart_tx_fifo_if wr_if ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DEPTH_LOG2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .wr    (wr_if),
    .tx    (tx),
    .busy  (busy),
    .level (level)
  );

  always #5 clock = ~clock;

  int         assert_count = 0;
  int         fail_count   = 0;
  logic [7:0] model_fifo[$];
  logic       frame_bits [0:10];
  int         frame_remain = 0;

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Serial frame as the line should carry it: start, 8 data LSB first,
  // optional even parity, stop.
  function automatic void loadFrame(input logic [7:0] b);
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame_bits[1 + i] = b[i];
`ifdef UART_TX_PARITY_EN
    frame_bits[9]  = ^b;
    frame_bits[10] = 1'b1;
`else
    frame_bits[9]  = 1'b1;
    frame_bits[10] = 1'b1;
`endif
  endfunction

  function automatic int curBit();
    return (FRAME_LEN - frame_remain) / CPB;
  endfunction

  // Reference behaviour at one rising edge. Acceptance uses the occupancy
  // before the edge; a new frame starts when idle or when the current frame
  // is on its final cycle and bytes are waiting.
  function automatic void modelEdge(input logic v, input logic [7:0] d, input logic r);
    bit accept;
    if (r) begin
      model_fifo.delete();
      frame_remain = 0;
    end else begin
      accept = v && (model_fifo.size() < DEPTH);
      if (frame_remain <= 1 && model_fifo.size() > 0) begin
        loadFrame(model_fifo.pop_front());
        frame_remain = FRAME_LEN;
      end else if (frame_remain > 0) begin
        frame_remain--;
      end
      if (accept) model_fifo.push_back(d);
    end
  endfunction

  // Drive one cycle of inputs, advance the model, then compare #1 after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic exp_tx;
    wr_if.wr_valid = v;
    wr_if.wr_data  = d;
    reset          = r;
    @(posedge clock);
    modelEdge(v, d, r);
    #1;
    exp_tx = (frame_remain > 0) ? frame_bits[curBit()] : 1'b1;
    checkOutput("tx", tx, exp_tx);
    checkOutput("level", level, model_fifo.size());
    checkOutput("busy", busy, (frame_remain > 0) || (model_fifo.size() > 0));
    checkOutput("wr_ready", wr_if.wr_ready, model_fifo.size() < DEPTH);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((frame_remain > 0 || model_fifo.size() > 0) && n < budget) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput("drainDone", busy, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL globalTimeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int acc;
    int peak;
    int n;

    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = 8'h00;

    // Reset, with a write attempt that must be ignored.
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hAB, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("resetLevel", level, 0);
    checkOutput("resetTx", tx, 1'b1);

    // Single byte into an empty FIFO: line still high after the accepting
    // edge, start bit on the following one.
    applyStimulus(1'b1, 8'h41, 1'b0);
    checkOutput("acceptTx", tx, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("startEdge", tx, 1'b0);
    drain(200);

    // Overfill while the first frame runs.
    applyStimulus(1'b1, 8'($urandom), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    acc  = 0;
    peak = 0;
    for (int i = 0; i < 17; i++) begin
      if (wr_if.wr_ready) acc++;
      applyStimulus(1'b1, 8'($urandom), 1'b0);
      if (int'(level) > peak) peak = int'(level);
    end
    checkOutput("accepted17", acc, 16);
    checkOutput("peakLevel", peak, 16);
    drain(2000);

    // Push coinciding with the pop at the end of STOP, at level 3.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
    n = 0;
    while (frame_remain != 1 && n < 200) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput("preStopLevel", level, 3);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    checkOutput("pushPopLevel", level, 3);
    drain(1000);

    // Reset during data bit 3 of 0xA5 with two bytes queued.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    n = 0;
    while (!(frame_remain > 0 && curBit() == 4) && n < 200) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      n++;
    end
    checkOutput("dataBit3", tx, 1'b0);
    checkOutput("queuedTwo", level, 2);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    checkOutput("abortTx", tx, 1'b1);
    checkOutput("abortLevel", level, 0);
    checkOutput("abortBusy", busy, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    drain(200);

    // Parity-sensitive pair, sent back-to-back.
    applyStimulus(1'b1, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h03, 1'b0);
    drain(300);

    // Randomised traffic: heavy then light load, occasional reset.
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic r;
      v = (i < 400) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 249) == 0);
      applyStimulus(v, 8'($urandom), r);
    end
    drain(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
